ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter that shares one RAMHelper memory port among `NUM_REQ` requesters (e.g. instruction fetch, data load/store, DMA) in simulation top-levels. Each requester issues one 64-bit-word read or masked write through a valid/ready handshake and receives a registered response. The block drives RAMHelper's `en/rIdx/wIdx/wdata/wmask/wen` and samples its combinational `rdata`. One access is in flight at a time.

## Interface
- `NUM_REQ`, 2: number of requesters, 1..8.
- `IDX_W`, 64: word-index width; zero-extended to 64 bits on the RAM side.

- `clk`  in  1  clock; RAMHelper shares it.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_wen`  in  NUM_REQ  1 = masked write, 0 = read.
- `req_idx`  in  NUM_REQ*IDX_W  word index; requester i occupies slice [i*IDX_W +: IDX_W].
- `req_wdata`  in  NUM_REQ*64  write data.
- `req_wmask`  in  NUM_REQ*64  bit-granular write mask.
- `resp_valid`  out  1  response valid.
- `resp_id`  out  3  requester index owning the response.
- `resp_rdata`  out  64  word value before the access; for writes this is the pre-write value.
- `resp_ready`  in  1  response consumer ready.
- `ram_en, ram_wen`  out  1  to RAMHelper `en`, `wen`.
- `ram_rIdx, ram_wIdx`  out  64  to RAMHelper; both equal the granted index.
- `ram_wdata, ram_wmask`  out  64  to RAMHelper.
- `ram_rdata`  in  64  from RAMHelper; combinational read.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant the first valid requester starting at `rr_ptr` and wrapping modulo NUM_REQ.
  - Assert `req_ready` for that requester only, combinationally.
  - On handshake, latch `idx/wen/wdata/wmask/id` into the command register, set `rr_ptr = grant+1` (wrapping NUM_REQ-1 -> 0), and go to ACCESS.
- ACCESS:
  - `ram_en=1`; `ram_wen` = latched wen; all RAM address and data outputs come from the command register.
  - Capture `ram_rdata` into `resp_rdata` at the cycle's closing edge. RAMHelper commits the write at that same edge, so the captured value is the pre-write value.
  - Go to RESP.
- RESP:
  - `resp_valid=1`; `resp_id` and `resp_rdata` are held stable.
  - On `resp_ready`, go to IDLE.
  - No new grant is issued while in RESP (`req_ready` is all zero).
- `ram_en` and `ram_wen` are 0 in every state except ACCESS.
- Outputs in non-ACCESS states:
  - `ram_wen=0`.
  - `ram_*Idx/wdata/wmask` hold their last value; don't-care but stable.
- A requester whose `req_valid` drops before it is granted loses nothing; arbitration is recomputed every IDLE cycle.
- `IDX_W < 64`: zero-extend the index to the RAM side.

## Timing
- Handshake at edge T -> ACCESS during cycle T+1 -> `resp_valid` from T+2.
- Minimum request-to-response latency: 2 cycles.
- Maximum throughput: one access per 3 cycles when `resp_ready` is held high.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - `resp_valid=0`, `resp_id=0`, `resp_rdata=0`.
  - `ram_en=0`, `ram_wen=0`, all RAM address and data outputs 0.
  - `req_ready` follows IDLE arbitration once reset deasserts.
- Reset asserted during ACCESS:
  - `ram_en` and `ram_wen` drop immediately, because they are asynchronously cleared registers.
  - No write is committed if reset is high at the edge.
  - The command and response are discarded.
- Reset asserted during RESP: the response is dropped and `resp_valid` goes 0 immediately.
- Simultaneous requests: the lowest index at or above `rr_ptr` wins. A requester holding `req_valid` waits at most NUM_REQ-1 grants.

## Structure
- Package `ram_arb_pkg`:
  - state enum {IDLE, ACCESS, RESP}.
  - `RAM_WORD_W=64`.
  - `ID_W=3`.
  - `MAX_REQ=8`.
- Sub-module `rr_arbiter`:
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register lives in the parent.
- Command and response registers and the FSM live in `ram_port_arbiter`.

## Test plan
- Single read: memory[0x10]=0xDEADBEEF_00C0FFEE; req0 reads idx 0x10 -> `resp_valid` at T+2, `resp_id=0`, `rdata=0xDEADBEEF_00C0FFEE`; `ram_en` high for exactly one cycle.
- Masked write then read:
  - memory[5]=0x1111_1111_1111_1111; req1 writes wdata=0xFFFF_FFFF_FFFF_FFFF, wmask=0x0000_0000_FFFF_0000 -> `resp_rdata=0x1111_1111_1111_1111`.
  - A following read of idx 5 -> `0x1111_1111_FFFF_1111`.
- Contention, NUM_REQ=2, both requesters valid continuously -> grants alternate 0,1,0,1. Each new grant comes 3 cycles after the previous one while `resp_ready=1`.
- Backpressure: hold `resp_ready=0` for 5 cycles in RESP:
  - `resp_valid`, `resp_id` and `resp_rdata` stay stable.
  - `req_ready` stays 0 and `ram_en` stays 0.
  - The next grant comes the cycle after `resp_ready` rises.
- Reset during ACCESS of a write to idx 7 (old value 0xAA):
  - `ram_en` drops in the same cycle; memory[7] stays 0xAA.
  - After release: state IDLE, `resp_valid=0`, `rr_ptr=0`.
- Round-robin wrap, NUM_REQ=3: the only valid requester is 2, then only 0 -> `rr_ptr` goes 0->0 (after grant to 2 it wraps to 0); requester 0 is granted next.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAMHelper port arbiter.
package ram_arb_pkg;

   localparam int RAM_WORD_W = 64;
   localparam int ID_W       = 3;
   localparam int MAX_REQ    = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above
// rr_ptr, wrapping modulo NUM_REQ. The pointer itself lives in the parent.
module rr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_vld
);

   // One extra bit so ptr + offset never overflows before the wrap.
   logic [ID_W:0] cand;

   // Walk offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ))
            cand = cand - (ID_W+1)'(NUM_REQ);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && (cand == (ID_W+1)'(i)) && req[i]) begin
               grant[i]  = 1'b1;
               grant_idx = ID_W'(i);
               grant_vld = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAMHelper port among NUM_REQ requesters, one access in flight.
// IDLE arbitrates, ACCESS drives the RAM for one cycle, RESP holds the result.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 64
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0]              req_wen,
   input  logic [NUM_REQ*IDX_W-1:0]        req_idx,
   input  logic [NUM_REQ*RAM_WORD_W-1:0]   req_wdata,
   input  logic [NUM_REQ*RAM_WORD_W-1:0]   req_wmask,
   output logic                            resp_valid,
   output logic [ID_W-1:0]                 resp_id,
   output logic [RAM_WORD_W-1:0]           resp_rdata,
   input  logic                            resp_ready,
   output logic                            ram_en,
   output logic                            ram_wen,
   output logic [RAM_WORD_W-1:0]           ram_rIdx,
   output logic [RAM_WORD_W-1:0]           ram_wIdx,
   output logic [RAM_WORD_W-1:0]           ram_wdata,
   output logic [RAM_WORD_W-1:0]           ram_wmask,
   input  logic [RAM_WORD_W-1:0]           ram_rdata
);

   if (NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("ram_port_arbiter: NUM_REQ must be 1..8");
   end

   state_t                state, state_nxt;
   logic [ID_W-1:0]       rr_ptr;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_W-1:0]       grant_idx;
   logic                  grant_vld;
   logic                  hs;

   logic [IDX_W-1:0]      sel_idx;
   logic                  sel_wen;
   logic [RAM_WORD_W-1:0] sel_wdata, sel_wmask;

   logic [IDX_W-1:0]      cmd_idx;
   logic [ID_W-1:0]       cmd_id;
   logic [RAM_WORD_W-1:0] cmd_wdata, cmd_wmask;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // Only IDLE offers a grant; the handshake is implied by a valid winner.
   assign req_ready = (state == IDLE) ? grant : '0;
   assign hs        = (state == IDLE) && grant_vld;

   // Pick the granted requester's command fields (grant is one-hot or zero).
   always_comb begin
      sel_idx   = '0;
      sel_wen   = 1'b0;
      sel_wdata = '0;
      sel_wmask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_idx   = req_idx[i*IDX_W +: IDX_W];
            sel_wen   = req_wen[i];
            sel_wdata = req_wdata[i*RAM_WORD_W +: RAM_WORD_W];
            sel_wmask = req_wmask[i*RAM_WORD_W +: RAM_WORD_W];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: ACCESS is always exactly one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Round-robin pointer moves past the winner on each handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rr_ptr <= '0;
      else if (hs)
         rr_ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
   end

   // Command register plus registered RAM strobes. ram_en/ram_wen are high
   // only in the cycle after a handshake (ACCESS) and clear asynchronously,
   // so a reset during ACCESS cannot commit a write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_en    <= 1'b0;
         ram_wen   <= 1'b0;
         cmd_idx   <= '0;
         cmd_id    <= '0;
         cmd_wdata <= '0;
         cmd_wmask <= '0;
      end else begin
         ram_en  <= hs;
         ram_wen <= hs & sel_wen;
         if (hs) begin
            cmd_idx   <= sel_idx;
            cmd_id    <= grant_idx;
            cmd_wdata <= sel_wdata;
            cmd_wmask <= sel_wmask;
         end
      end
   end

   // Response capture at the end of ACCESS; RAM commits at the same edge,
   // so writes return the pre-write word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_rdata <= '0;
         resp_id    <= '0;
      end else if (state == ACCESS) begin
         resp_rdata <= ram_rdata;
         resp_id    <= cmd_id;
      end
   end

   assign resp_valid = (state == RESP);
   assign ram_rIdx   = RAM_WORD_W'(cmd_idx);
   assign ram_wIdx   = RAM_WORD_W'(cmd_idx);
   assign ram_wdata  = cmd_wdata;
   assign ram_wmask  = cmd_wmask;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural RAMHelper.
module tb_ram_port_arbiter;

   localparam int NR = 3;
   localparam int IW = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic [NR-1:0]      req_valid, req_ready, req_wen;
   logic [NR*IW-1:0]   req_idx;
   logic [NR*64-1:0]   req_wdata, req_wmask;
   logic               resp_valid, resp_ready;
   logic [2:0]         resp_id;
   logic [63:0]        resp_rdata;
   logic               ram_en, ram_wen;
   logic [63:0]        ram_rIdx, ram_wIdx, ram_wdata, ram_wmask, ram_rdata;

   always #5 clk = ~clk;

   ram_port_arbiter #(.NUM_REQ(NR), .IDX_W(IW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_idx(req_idx), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata),
      .resp_ready(resp_ready),
      .ram_en(ram_en), .ram_wen(ram_wen), .ram_rIdx(ram_rIdx), .ram_wIdx(ram_wIdx),
      .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
   );

   // RAMHelper stand-in: combinational read, masked write at the clock edge.
   logic [63:0] mem [0:255];
   logic        pl_en;
   logic [7:0]  pl_idx;
   logic [63:0] pl_val;
   assign ram_rdata = mem[ram_rIdx[7:0]];
   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      else if (ram_en && ram_wen)
         mem[ram_wIdx[7:0]] <= (mem[ram_wIdx[7:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
   end

   int checks = 0, errors = 0, cyc = 0, en_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (ram_en) en_cnt <= en_cnt + 1;

   typedef struct packed { logic [2:0] id; logic [63:0] data; } exp_t;
   exp_t        sb[$];
   logic [63:0] ref_mem [0:255];
   int          grant_ids[$], grant_cycs[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Response side of the scoreboard.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && resp_valid && resp_ready) begin
         if (sb.size() == 0) chk("sb_empty", 64'(sb.size()), 64'd1);
         else begin
            e = sb.pop_front();
            chk("resp_id", 64'(resp_id), 64'(e.id));
            chk("resp_rdata", resp_rdata, e.data);
         end
      end
   end

   // Called at negedge: if a handshake will happen at the next edge, push the
   // expected response and update the reference memory.
   task automatic sb_neg();
      logic [NR-1:0] h;
      logic [IW-1:0] ix;
      logic [63:0]   old, wd, wm;
      h = req_valid & req_ready;
      if (h != '0) chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
      for (int i = 0; i < NR; i++) begin
         if (h[i]) begin
            ix  = req_idx[i*IW +: IW];
            wd  = req_wdata[i*64 +: 64];
            wm  = req_wmask[i*64 +: 64];
            old = ref_mem[ix[7:0]];
            sb.push_back(exp_t'{id: 3'(i), data: old});
            if (req_wen[i]) ref_mem[ix[7:0]] = (old & ~wm) | (wd & wm);
            grant_ids.push_back(i);
            grant_cycs.push_back(cyc);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk); sb_neg(); @(posedge clk); #1;
   endtask

   task automatic preload(input logic [7:0] idx, input logic [63:0] val);
      pl_en = 1'b1; pl_idx = idx; pl_val = val; ref_mem[idx] = val;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic set_req(input int i, input logic wen, input logic [IW-1:0] idx,
                          input logic [63:0] wd, input logic [63:0] wm);
      req_wen[i]             = wen;
      req_idx[i*IW +: IW]    = idx;
      req_wdata[i*64 +: 64]  = wd;
      req_wmask[i*64 +: 64]  = wm;
   endtask

   // Raise one request, wait (bounded) for its handshake edge, then drop it.
   task automatic do_req(input int i, input logic wen, input logic [IW-1:0] idx,
                         input logic [63:0] wd, input logic [63:0] wm);
      logic got;
      set_req(i, wen, idx, wd, wm);
      req_valid[i] = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk); got = req_ready[i]; sb_neg(); @(posedge clk); #1;
      end
      chk("granted", 64'(got), 64'd1);
      req_valid[i] = 1'b0;
   endtask

   // One ACCESS cycle: RAM strobes and command outputs.
   task automatic chk_access(input logic wen, input logic [IW-1:0] idx,
                             input logic [63:0] wd, input logic [63:0] wm);
      @(negedge clk);
      chk("acc_en", 64'(ram_en), 64'd1);
      chk("acc_wen", 64'(ram_wen), 64'(wen));
      chk("acc_ridx", ram_rIdx, 64'(idx));
      chk("acc_widx", ram_wIdx, 64'(idx));
      chk("acc_rv", 64'(resp_valid), 64'd0);
      if (wen) begin
         chk("acc_wdata", ram_wdata, wd);
         chk("acc_wmask", ram_wmask, wm);
      end
      sb_neg(); @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
      chk("drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int e0;
      reset = 1'b1; req_valid = '0; req_wen = '0; req_idx = '0;
      req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;
      pl_en = 1'b0; pl_idx = '0; pl_val = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_rv", 64'(resp_valid), 64'd0);
      chk("rst_rid", 64'(resp_id), 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      chk("rst_en", 64'(ram_en), 64'd0);
      chk("rst_wen", 64'(ram_wen), 64'd0);
      chk("rst_ridx", ram_rIdx, 64'd0);
      chk("rst_widx", ram_wIdx, 64'd0);
      chk("rst_wdata", ram_wdata, 64'd0);
      chk("rst_wmask", ram_wmask, 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      preload(8'h10, 64'hDEAD_BEEF_00C0_FFEE);
      preload(8'h05, 64'h1111_1111_1111_1111);
      preload(8'h07, 64'h0000_0000_0000_00AA);
      preload(8'h20, 64'hA5A5_0000_0000_0020);
      preload(8'h21, 64'h5A5A_0000_0000_0021);
      preload(8'h30, 64'h0123_4567_89AB_CDEF);
      reset = 1'b0;
      @(posedge clk); #1;

      // Single read: resp_valid two cycles after the handshake, one ram_en pulse.
      e0 = en_cnt;
      do_req(0, 1'b0, 16'h10, 64'd0, 64'd0);
      chk_access(1'b0, 16'h10, 64'd0, 64'd0);
      @(negedge clk);
      chk("rd_rv_t2", 64'(resp_valid), 64'd1);
      chk("rd_en_off", 64'(ram_en), 64'd0);
      sb_neg(); @(posedge clk); #1;
      drain();
      chk("rd_en_pulses", 64'(en_cnt - e0), 64'd1);

      // Masked write, then read back the merged word.
      do_req(1, 1'b1, 16'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000);
      chk_access(1'b1, 16'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000);
      drain();
      chk("wr_mem5", mem[5], 64'h1111_1111_FFFF_1111);
      do_req(1, 1'b0, 16'h5, 64'd0, 64'd0);
      chk_access(1'b0, 16'h5, 64'd0, 64'd0);
      drain();

      // Contention: requesters 0 and 1 valid continuously (pointer at 2).
      grant_ids.delete(); grant_cycs.delete();
      set_req(0, 1'b0, 16'h20, 64'd0, 64'd0);
      set_req(1, 1'b0, 16'h21, 64'd0, 64'd0);
      req_valid = 3'b011;
      repeat (12) tick();
      req_valid = '0;
      drain();
      chk("cont_count", 64'(grant_ids.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         if (grant_ids.size() > k) begin
            chk("cont_id", 64'(grant_ids[k]), 64'(k % 2));
            if (k > 0) chk("cont_gap", 64'(grant_cycs[k] - grant_cycs[k-1]), 64'd3);
         end
      end

      // Backpressure: RESP held for 5 cycles with a competing request pending.
      resp_ready = 1'b0;
      do_req(2, 1'b0, 16'h30, 64'd0, 64'd0);
      tick();
      set_req(0, 1'b0, 16'h10, 64'd0, 64'd0);
      req_valid[0] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_rv", 64'(resp_valid), 64'd1);
         chk("bp_rid", 64'(resp_id), 64'd2);
         chk("bp_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
         chk("bp_ready", 64'(req_ready), 64'd0);
         chk("bp_en", 64'(ram_en), 64'd0);
         sb_neg(); @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_last", 64'(req_ready), 64'd0);
      sb_neg(); @(posedge clk); #1;
      @(negedge clk);
      chk("bp_next_grant", 64'(req_ready), 64'b001);
      sb_neg(); @(posedge clk); #1;
      req_valid = '0;
      chk_access(1'b0, 16'h10, 64'd0, 64'd0);
      drain();

      // Reset during ACCESS of a write to idx 7: no commit, all discarded.
      do_req(0, 1'b1, 16'h7, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("rst_acc_en_pre", 64'(ram_en), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_acc_en", 64'(ram_en), 64'd0);
      chk("rst_acc_wen", 64'(ram_wen), 64'd0);
      chk("rst_acc_rv", 64'(resp_valid), 64'd0);
      sb.delete();
      ref_mem[7] = 64'hAA;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mem7", mem[7], 64'hAA);
      chk("rst_rv_after", 64'(resp_valid), 64'd0);
      chk("rst_en_after", 64'(ram_en), 64'd0);
      @(posedge clk); #1;
      set_req(0, 1'b0, 16'h10, 64'd0, 64'd0);
      set_req(1, 1'b0, 16'h20, 64'd0, 64'd0);
      set_req(2, 1'b0, 16'h21, 64'd0, 64'd0);
      req_valid = 3'b111;
      @(negedge clk);
      chk("rst_ptr_zero", 64'(req_ready), 64'b001);
      sb_neg(); @(posedge clk); #1;
      req_valid = '0;
      drain();

      // Wrap: only requester 2, then 0 and 1 together -> 0 wins.
      set_req(2, 1'b0, 16'h21, 64'd0, 64'd0);
      req_valid = 3'b100;
      @(negedge clk);
      chk("wrap_g2", 64'(req_ready), 64'b100);
      sb_neg(); @(posedge clk); #1;
      req_valid = '0;
      chk_access(1'b0, 16'h21, 64'd0, 64'd0);
      drain();
      set_req(0, 1'b0, 16'h20, 64'd0, 64'd0);
      set_req(1, 1'b0, 16'h5, 64'd0, 64'd0);
      req_valid = 3'b011;
      @(negedge clk);
      chk("wrap_g0", 64'(req_ready), 64'b001);
      sb_neg(); @(posedge clk); #1;
      req_valid = '0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
